// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
// State encodings, requester IDs and the DMType access-size codes.
package dmem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // DMType codes shared with the pipeline control decoder
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    function automatic logic is_bus_busy(input arb_state_e state);
        return (state == ST_ISSUE) || (state == ST_WAIT);
    endfunction

endpackage

// File: rtl/dmem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester
// that did not win last time is chosen.
module rr_arb2
    import dmem_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = REQ_CPU;
        case (i_req)
            2'b10:   o_gnt_id = REQ_DMA;
            2'b11:   o_gnt_id = ~i_last_gnt;
            default: o_gnt_id = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// CPU/DMA arbiter for the shared data-memory port; registers the winning request onto the bus.
// Optional mem_ready timeout with bus_err pulse is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [2:0]        r0_dmtype,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [2:0]        r1_dmtype,
    output logic              r1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_dmtype,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arb_state_e        r_state, w_state_next;
    logic              r_gnt_id;
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_dmtype;
    logic [DATA_W-1:0] r_rdata;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_grant;
    logic              w_busy;
    logic              w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_req       ({r1_req, r0_req}),
        .i_last_gnt  (r_last_gnt),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_busy  = is_bus_busy(r_state);

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_cnt;
    logic            r_err;

    assign w_timeout = w_busy && !mem_ready && (r_cnt >= CntW'(TIMEOUT));

    // Counter sits at zero in IDLE, so it is clear on every ISSUE entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CntW'(1);
                if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    assign bus_err = (r_state == ST_DONE) && r_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_valid) w_state_next = ST_ISSUE;
            ST_ISSUE,
            ST_WAIT:  begin
                if (mem_ready || w_timeout) w_state_next = ST_DONE;
                else                        w_state_next = ST_WAIT;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_id   <= REQ_CPU;
            r_last_gnt <= REQ_DMA;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dmtype   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_id <= w_gnt_id;
                r_we     <= (w_gnt_id == REQ_DMA) ? r1_we     : r0_we;
                r_addr   <= (w_gnt_id == REQ_DMA) ? r1_addr   : r0_addr;
                r_wdata  <= (w_gnt_id == REQ_DMA) ? r1_wdata  : r0_wdata;
                r_dmtype <= (w_gnt_id == REQ_DMA) ? r1_dmtype : r0_dmtype;
            end
            // Writes and timed-out accesses return zero data
            if (w_busy && mem_ready)  r_rdata <= r_we ? '0 : mem_rdata;
            else if (w_timeout)       r_rdata <= '0;
            if (r_state == ST_DONE)   r_last_gnt <= r_gnt_id;
        end
    end

    assign mem_req    = w_busy;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_dmtype = r_dmtype;
    assign r0_done    = (r_state == ST_DONE) && (r_gnt_id == REQ_CPU);
    assign r1_done    = (r_state == ST_DONE) && (r_gnt_id == REQ_DMA);
    assign rdata      = (r_state == ST_DONE) ? r_rdata : '0;
    assign cpu_stall  = r0_req && !r0_done;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a completion scoreboard.
// Define DMEM_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_dmem_bus_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [2:0]  r0_dmtype, r1_dmtype;
    logic        r0_done, r1_done, cpu_stall, mem_req, mem_we, mem_ready, bus_err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_dmtype;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r0_dmtype  (r0_dmtype),
        .r0_done    (r0_done),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r1_dmtype  (r1_dmtype),
        .r1_done    (r1_done),
        .rdata      (rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_dmtype (mem_dmtype),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every done pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (r0_done || r1_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'({r1_done, r0_done}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_id", 32'({r1_done, r0_done}), e.id ? 32'd2 : 32'd1);
                check("done_rdata", rdata, e.data);
                check("done_bus_err", 32'(bus_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    initial begin
        int k;
        reset = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_dmtype = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_dmtype = 0;
        mem_rdata = 0; mem_ready = 0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_done", 32'({r1_done, r0_done}), 0);
        check("rst_rdata", rdata, 0);
        check("rst_bus_err", 32'(bus_err), 0);
        check("rst_mem_addr", mem_addr, 0);
        step();
        reset = 1'b0;

        // CPU read, zero-wait memory (mem_ready held high, ignored in IDLE)
        step();
        r0_req = 1; r0_addr = 32'h10; r0_we = 0; r0_dmtype = 3'b000;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        check("c0_stall", 32'(cpu_stall), 1);
        check("c0_mem_req", 32'(mem_req), 0);
        step();
        @(negedge clk);
        check("c1_mem_req", 32'(mem_req), 1);
        check("c1_mem_addr", mem_addr, 32'h10);
        check("c1_stall", 32'(cpu_stall), 1);
        step();
        @(negedge clk);
        check("c2_r0_done", 32'(r0_done), 1);
        check("c2_stall", 32'(cpu_stall), 0);
        check("c2_mem_req", 32'(mem_req), 0);
        step();
        r0_req = 0; mem_ready = 0;

        // DMA write, three wait cycles
        step();
        r1_req = 1; r1_we = 1; r1_addr = 32'h20; r1_wdata = 32'h12345678; r1_dmtype = 3'b011;
        sb.push_back('{1'b1, 32'h0, 1'b0});
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                mem_ready = 1; mem_rdata = 32'hCAFEF00D;
            end
            @(negedge clk);
            check("w_mem_req", 32'(mem_req), 1);
            check("w_mem_we", 32'(mem_we), 1);
            check("w_mem_wdata", mem_wdata, 32'h12345678);
            check("w_mem_addr", mem_addr, 32'h20);
            check("w_mem_dmtype", 32'(mem_dmtype), 32'd3);
            check("w_no_done", 32'({r1_done, r0_done}), 0);
        end
        step();
        mem_ready = 0;
        @(negedge clk);
        check("w_r1_done", 32'(r1_done), 1);
        check("w_r0_quiet", 32'(r0_done), 0);
        step();
        r1_req = 0; r1_we = 0;

        // CPU read with r0_addr changed while in WAIT
        step();
        r0_req = 1; r0_addr = 32'h10;
        sb.push_back('{1'b0, 32'h0BADCAFE, 1'b0});
        step();
        step();
        r0_addr = 32'h99;
        @(negedge clk);
        check("hold_addr_wait", mem_addr, 32'h10);
        step();
        mem_ready = 1; mem_rdata = 32'h0BADCAFE;
        @(negedge clk);
        check("hold_addr_ready", mem_addr, 32'h10);
        step();
        step();
        r0_req = 0; mem_ready = 0;

        // Reset during a DMA WAIT aborts it; afterwards dual requests alternate from the CPU
        step();
        r1_req = 1; r1_we = 0; r1_addr = 32'h20;
        step();
        step();
        #2;
        check("pre_rst_busy", 32'(mem_req), 1);
        reset = 1;
        #1;
        check("rst_async_mem_req", 32'(mem_req), 0);
        check("rst_no_done", 32'(r1_done), 0);
        step();
        step();
        reset = 0;
        r0_req = 1; r0_addr = 32'h10;
        mem_ready = 1; mem_rdata = 32'h55AA55AA;
        for (int j = 0; j < 4; j++) sb.push_back('{1'(j % 2), 32'h55AA55AA, 1'b0});
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) check("post_rst_idle", 32'(mem_req), 0);
            if (mem_req) begin
                check("rr_mem_addr", mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
                k++;
            end
            step();
        end
        check("rr_grant_count", k, 4);
        r0_req = 0; r1_req = 0; mem_ready = 0; r0_addr = 32'h40;

        // Memory never answers
        step();
        r0_req = 1;
`ifdef DMEM_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 32'h0, 1'b1});
        for (int c = 1; c <= 10; c++) begin
            step();
            @(negedge clk);
            if (c < 10) begin
                check("to_no_err", 32'(bus_err), 0);
                check("to_no_done", 32'(r0_done), 0);
            end else begin
                check("to_bus_err", 32'(bus_err), 1);
                check("to_r0_done", 32'(r0_done), 1);
                check("to_rdata", rdata, 0);
            end
        end
        step();
        r0_req = 0;
`else
        for (int c = 0; c < 100; c++) step();
        @(negedge clk);
        check("hang_mem_req", 32'(mem_req), 1);
        check("hang_mem_addr", mem_addr, 32'h40);
        check("hang_bus_err", 32'(bus_err), 0);
        step();
        reset = 1; r0_req = 0;
        step();
        reset = 0;
`endif
        repeat (4) step();
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
